// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types and constants for the hpdcache SRAM controller.
package hpdcache_sram_ctrl_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } ctrl_state_t;

  // Number of read responses that can be buffered (in flight + stored).
  localparam int unsigned RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/hpdcache_sram_rsp_fifo.sv
// Two-entry response FIFO holding SRAM read data until the consumer takes it.
module hpdcache_sram_rsp_fifo
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [1:0]           count,
  output logic [DATA_SIZE-1:0] head
);

  logic [DATA_SIZE-1:0] mem [RSP_FIFO_DEPTH];
  logic                 wr_ptr;
  logic                 rd_ptr;

  // Storage is written without reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; push and pop together keep count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/hpdcache_sram_ctrl.sv
// Initiator for a single-port SRAM: clears the array after reset, then turns a
// valid/ready request stream into SRAM accesses with buffered read responses.
module hpdcache_sram_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE  = 6,
  parameter int unsigned          DATA_SIZE  = 28,
  parameter int unsigned          DEPTH      = 2**ADDR_SIZE,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADDR_SIZE-1:0] req_addr_i,
  input  logic [DATA_SIZE-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_SIZE-1:0] rsp_rdata_o,
  output logic                 init_done_o,
  output logic                 sram_cs_o,
  output logic                 sram_we_o,
  output logic [ADDR_SIZE-1:0] sram_addr_o,
  output logic [DATA_SIZE-1:0] sram_wdata_o,
  input  logic [DATA_SIZE-1:0] sram_rdata_i
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  ctrl_state_t          state, state_next;
  logic [ADDR_SIZE-1:0] init_cnt;
  logic                 inflight;
  logic [1:0]           fifo_count;
  logic                 accept;
  logic                 pop;
  logic [2:0]           occupancy;

  assign pop       = rsp_valid_o & rsp_ready_i;
  assign accept    = req_valid_i & req_ready_o;
  // Slots committed after this cycle: stored + arriving next edge - leaving now.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};

  // State register and init sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Leave INIT after the write to the last address.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (init_cnt == LAST_ADDR) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  // SRAM drive and handshake outputs per state.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    req_ready_o  = 1'b0;
    init_done_o  = 1'b0;
    case (state)
      ST_INIT: begin
        sram_cs_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = init_cnt;
        sram_wdata_o = INIT_VALUE;
      end
      ST_READY: begin
        init_done_o  = 1'b1;
        req_ready_o  = (occupancy < 3'(RSP_FIFO_DEPTH));
        sram_cs_o    = accept;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
      end
      default: ;
    endcase
  end

  // A read accepted this cycle returns SRAM data next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= accept & ~req_we_i;
    end
  end

  hpdcache_sram_rsp_fifo #(
    .DATA_SIZE (DATA_SIZE)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (sram_rdata_i),
    .pop       (pop),
    .count     (fifo_count),
    .head      (rsp_rdata_o)
  );

  assign rsp_valid_o = (fifo_count != 2'd0);

endmodule

// File: tb/tb_hpdcache_sram_ctrl.sv
// Directed bench for hpdcache_sram_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_hpdcache_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [5:0]  req_addr_i = '0;
  logic [27:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [27:0] rsp_rdata_o;
  logic        init_done_o;
  logic        sram_cs_o;
  logic        sram_we_o;
  logic [5:0]  sram_addr_o;
  logic [27:0] sram_wdata_o;
  logic [27:0] sram_rdata_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [27:0] sram_mem [64];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs_o) begin
      if (sram_we_o) sram_mem[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i <= sram_mem[sram_addr_o];
    end
  end

  hpdcache_sram_ctrl #(
    .ADDR_SIZE  (6),
    .DATA_SIZE  (28),
    .DEPTH      (64),
    .INIT_VALUE (28'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .init_done_o  (init_done_o),
    .sram_cs_o    (sram_cs_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_init_done", 32'(init_done_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    rst = 1'b0;

    // Init sweep: 64 writes of zero, addresses 0..63
    for (int i = 0; i < 64; i++) begin
      #1;
      check("init_cs",    32'(sram_cs_o),    32'd1);
      check("init_we",    32'(sram_we_o),    32'd1);
      check("init_addr",  32'(sram_addr_o),  32'(i));
      check("init_wdata", 32'(sram_wdata_o), 32'd0);
      check("init_ready", 32'(req_ready_o),  32'd0);
      check("init_done0", 32'(init_done_o),  32'd0);
      @(negedge clk);
    end
    #1;
    check("init_done1",  32'(init_done_o), 32'd1);
    check("ready_after", 32'(req_ready_o), 32'd1);

    // Write then read back addr 5, latency 2
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 6'd5; req_wdata_i = 28'hABCDEF0;
    #1;
    check("wr_ready", 32'(req_ready_o),  32'd1);
    check("wr_cs",    32'(sram_cs_o),    32'd1);
    check("wr_we",    32'(sram_we_o),    32'd1);
    check("wr_addr",  32'(sram_addr_o),  32'd5);
    check("wr_wdata", 32'(sram_wdata_o), 32'hABCDEF0);
    @(negedge clk);
    req_we_i = 1'b0;
    #1;
    check("rd_cs",        32'(sram_cs_o),   32'd1);
    check("rd_we",        32'(sram_we_o),   32'd0);
    check("rd_ready",     32'(req_ready_o), 32'd1);
    check("wr_no_rsp",    32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    check("rd_t1_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    #1;
    check("rd_t2_valid", 32'(rsp_valid_o), 32'd1);
    check("rd_t2_data",  32'(rsp_rdata_o), 32'hABCDEF0);
    @(negedge clk);
    #1;
    check("rd_drained", 32'(rsp_valid_o), 32'd0);

    // Never-written address reads back the init value
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'd9;
    #1;
    check("rd9_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    #1;
    check("rd9_valid", 32'(rsp_valid_o), 32'd1);
    check("rd9_data",  32'(rsp_rdata_o), 32'd0);

    // Fill addr 0..7 with distinct data
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 6'(i); req_wdata_i = 28'hA00000 + 28'(i);
      #1;
      check("fill_ready", 32'(req_ready_o), 32'd1);
    end

    // 8 back-to-back reads with rsp_ready_i=1
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) begin
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'(c);
      end else begin
        req_valid_i = 1'b0;
      end
      #1;
      check("b2b_ready", 32'(req_ready_o), 32'd1);
      if (c >= 2) begin
        check("b2b_valid", 32'(rsp_valid_o), 32'd1);
        check("b2b_data",  32'(rsp_rdata_o), 32'hA00000 + 32'(c - 2));
      end else begin
        check("b2b_valid0", 32'(rsp_valid_o), 32'd0);
      end
    end
    @(negedge clk);
    #1;
    check("b2b_done", 32'(rsp_valid_o), 32'd0);

    // Backpressure: two reads accepted, then stall, then drain
    rsp_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'd1;
    #1;
    check("bp_c0_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_addr_i = 6'd2;
    #1;
    check("bp_c1_ready", 32'(req_ready_o), 32'd1);
    check("bp_c1_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    req_addr_i = 6'd3;
    #1;
    check("bp_c2_ready", 32'(req_ready_o), 32'd0);
    check("bp_c2_cs",    32'(sram_cs_o),   32'd0);
    check("bp_c2_valid", 32'(rsp_valid_o), 32'd1);
    check("bp_c2_data",  32'(rsp_rdata_o), 32'hA00001);
    for (int c = 3; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("bp_hold_ready", 32'(req_ready_o), 32'd0);
      check("bp_hold_data",  32'(rsp_rdata_o), 32'hA00001);
    end
    @(negedge clk);
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    #1;
    check("bp_c5_ready", 32'(req_ready_o), 32'd1);
    check("bp_c5_valid", 32'(rsp_valid_o), 32'd1);
    check("bp_c5_data",  32'(rsp_rdata_o), 32'hA00001);
    @(negedge clk);
    #1;
    check("bp_c6_ready", 32'(req_ready_o), 32'd1);
    check("bp_c6_valid", 32'(rsp_valid_o), 32'd1);
    check("bp_c6_data",  32'(rsp_rdata_o), 32'hA00002);
    @(negedge clk);
    #1;
    check("bp_c7_valid", 32'(rsp_valid_o), 32'd0);
    check("bp_c7_ready", 32'(req_ready_o), 32'd1);

    // Reset with one read buffered and one in flight
    rsp_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'd3;
    #1;
    check("mr_c0_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_addr_i = 6'd4;
    #1;
    check("mr_c1_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0; rst = 1'b1;
    #1;
    check("mr_c2_valid", 32'(rsp_valid_o), 32'd1);
    @(negedge clk);
    #1;
    check("mr_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("mr_init_done", 32'(init_done_o), 32'd0);
    check("mr_req_ready", 32'(req_ready_o), 32'd0);
    rst = 1'b0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      check("reinit_addr",  32'(sram_addr_o), 32'(i));
      check("reinit_cs",    32'(sram_cs_o),   32'd1);
      check("reinit_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
    end
    #1;
    check("reinit_done",  32'(init_done_o), 32'd1);
    check("reinit_valid", 32'(rsp_valid_o), 32'd0);

    // Data written before reset is cleared by the new sweep
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'd3;
    #1;
    check("post_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    check("post_t1_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    #1;
    check("post_valid", 32'(rsp_valid_o), 32'd1);
    check("post_data",  32'(rsp_rdata_o), 32'd0);
    @(negedge clk);
    #1;
    check("post_drained", 32'(rsp_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
